// File: rtl/cave_pkg.sv
// cave_pkg: shared DDR bus widths, requester indices and arbiter state encoding.
package cave_pkg;
  localparam int DDR_ADDR_W = 32;
  localparam int DDR_DATA_W = 64;
  localparam int DDR_BURST_W = 8;
  localparam int REQ_DOWNLOAD = 0;
  localparam int REQ_FB = 1;
  localparam int REQ_GFX = 2;
  typedef enum logic [1:0] {IDLE, READ_CMD, READ_DATA, WRITE} ddr_arb_state_t;
endpackage

// File: rtl/rr_picker.sv
// rr_picker: combinational round-robin one-hot select starting just after the last winner.
module rr_picker #(
  parameter int N = 3,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);
  logic [IW-1:0] c;
  // Scan from farthest to nearest so the nearest requester after last wins.
  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    c = '0;
    for (int k = N; k >= 1; k--) begin
      c = IW'((int'(last) + k) % N);
      if (req[c]) begin
        gnt = N'(1) << c;
        idx = c;
        any = 1'b1;
      end
    end
  end
endmodule

// File: rtl/ddr_arbiter.sv
// ddr_arbiter: round-robin share of one Avalon-MM burst DDR port; grant held for a whole burst.
module ddr_arbiter
  import cave_pkg::*;
#(
  parameter int N = REQ_GFX + 1,
  parameter int ADDR_W = DDR_ADDR_W,
  parameter int DATA_W = DDR_DATA_W,
  parameter int BURST_W = DDR_BURST_W
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [N-1:0]          in_rd,
  input  logic [N-1:0]          in_wr,
  input  logic [N*ADDR_W-1:0]   in_addr,
  input  logic [N*BURST_W-1:0]  in_burstCount,
  input  logic [N*DATA_W/8-1:0] in_mask,
  input  logic [N*DATA_W-1:0]   in_din,
  output logic [N-1:0]          in_waitReq,
  output logic [N-1:0]          in_valid,
  output logic [DATA_W-1:0]     in_dout,
  output logic                  ddr_rd,
  output logic                  ddr_wr,
  output logic [ADDR_W-1:0]     ddr_addr,
  output logic [BURST_W-1:0]    ddr_burstCount,
  output logic [DATA_W/8-1:0]   ddr_mask,
  output logic [DATA_W-1:0]     ddr_din,
  input  logic                  ddr_waitReq,
  input  logic                  ddr_valid,
  input  logic [DATA_W-1:0]     ddr_dout,
  output logic                  busy,
  output logic [N-1:0]          grant
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int MW = DATA_W / 8;
  ddr_arb_state_t state_q, state_d;
  logic [N-1:0] grant_q, grant_d, pick;
  logic [IW-1:0] last_q, last_d, pick_idx;
  logic [BURST_W-1:0] beats_q, beats_d, len, rem;
  logic pick_any, g_rd, g_wr, acc_rd, acc_wr;
  rr_picker #(.N(N), .IW(IW)) u_pick (
    .req (in_rd | in_wr),
    .last(last_q),
    .gnt (pick),
    .idx (pick_idx),
    .any (pick_any)
  );
  // While busy, last_q is the granted index and selects the command fields.
  always_comb begin
    g_rd = 1'b0;
    g_wr = 1'b0;
    ddr_addr = '0;
    ddr_burstCount = '0;
    ddr_mask = '0;
    ddr_din = '0;
    for (int i = 0; i < N; i++)
      if (last_q == IW'(i)) begin
        g_rd = in_rd[i];
        g_wr = in_wr[i];
        ddr_addr = in_addr[i*ADDR_W +: ADDR_W];
        ddr_burstCount = in_burstCount[i*BURST_W +: BURST_W];
        ddr_mask = in_mask[i*MW +: MW];
        ddr_din = in_din[i*DATA_W +: DATA_W];
      end
  end
  assign ddr_rd = (state_q == READ_CMD) && g_rd;
  assign ddr_wr = (state_q == WRITE) && g_wr;
  assign acc_rd = ddr_rd && !ddr_waitReq;
  assign acc_wr = ddr_wr && !ddr_waitReq;
  assign len = (ddr_burstCount == '0) ? BURST_W'(1) : ddr_burstCount;
  assign rem = (beats_q == '0) ? len : beats_q;
  assign busy = state_q != IDLE;
  assign grant = grant_q;
  assign in_dout = ddr_dout;
  assign in_waitReq = ~grant_q | {N{ddr_waitReq}};
  assign in_valid = (ddr_valid && (state_q == READ_DATA || acc_rd)) ? grant_q : '0;
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d = last_q;
    beats_d = beats_q;
    case (state_q)
      IDLE:
        if (pick_any) begin
          grant_d = pick;
          last_d = pick_idx;
          beats_d = '0;
          state_d = in_rd[pick_idx] ? READ_CMD : WRITE;
        end
      READ_CMD:
        if (!g_rd) state_d = IDLE;
        else if (acc_rd) begin
          beats_d = ddr_valid ? len - 1'b1 : len;
          state_d = (ddr_valid && len == BURST_W'(1)) ? IDLE : READ_DATA;
        end
      READ_DATA:
        if (ddr_valid) begin
          beats_d = beats_q - 1'b1;
          state_d = (beats_q == BURST_W'(1)) ? IDLE : READ_DATA;
        end
      WRITE:
        if (acc_wr) begin
          beats_d = rem - 1'b1;
          state_d = (rem == BURST_W'(1)) ? IDLE : WRITE;
        end else if (!g_wr && beats_q == '0) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (state_d == IDLE) grant_d = '0;
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q <= IW'(N - 1);
      beats_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q <= last_d;
      beats_q <= beats_d;
    end
endmodule

// File: tb/tb_ddr_arbiter.sv
// tb_ddr_arbiter: directed scenario tasks with hand-computed expectations for ddr_arbiter.
module tb_ddr_arbiter;
  logic clock = 1'b0, reset = 1'b1;
  logic [2:0] rd = '0, wr = '0;
  logic [95:0] addr = '0;
  logic [23:0] bc = '0, mask = '0;
  logic [191:0] din = '0;
  logic [2:0] in_waitReq, in_valid, grant;
  logic [63:0] in_dout, ddr_din;
  logic ddr_rd, ddr_wr, busy;
  logic [31:0] ddr_addr;
  logic [7:0] ddr_burstCount, ddr_mask;
  logic ddr_waitReq = 1'b0, ddr_valid = 1'b0;
  logic [63:0] ddr_dout = '0;
  int tests = 0, fails = 0;
  always #5 clock = ~clock;
  ddr_arbiter dut (
    .clock(clock), .reset(reset), .in_rd(rd), .in_wr(wr), .in_addr(addr),
    .in_burstCount(bc), .in_mask(mask), .in_din(din), .in_waitReq(in_waitReq),
    .in_valid(in_valid), .in_dout(in_dout), .ddr_rd(ddr_rd), .ddr_wr(ddr_wr),
    .ddr_addr(ddr_addr), .ddr_burstCount(ddr_burstCount), .ddr_mask(ddr_mask),
    .ddr_din(ddr_din), .ddr_waitReq(ddr_waitReq), .ddr_valid(ddr_valid),
    .ddr_dout(ddr_dout), .busy(busy), .grant(grant)
  );
  task automatic cyc;
    @(posedge clock);
    #2;
  endtask
  task automatic set_cmd(input int i, input logic [31:0] a, input logic [7:0] b, input logic [63:0] d);
    addr[i*32 +: 32] = a;
    bc[i*8 +: 8] = b;
    mask[i*8 +: 8] = 8'hFF;
    din[i*64 +: 64] = d;
  endtask
  task automatic test_reset;
    reset = 1'b1;
    cyc();
    cyc();
    #1;
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", busy); end
    tests++; if (grant !== 3'b000) begin fails++; $display("FAIL reset_grant got %b want 000", grant); end
    tests++; if (in_waitReq !== 3'b111) begin fails++; $display("FAIL reset_waitreq got %b want 111", in_waitReq); end
    tests++; if ({ddr_rd, ddr_wr, in_valid} !== 5'b0) begin fails++; $display("FAIL reset_cmd got %b want 00000", {ddr_rd, ddr_wr, in_valid}); end
    reset = 1'b0;
  endtask
  task automatic test_single_read;
    logic [7:0] pat = 8'b1001_1010;
    int n = 0;
    set_cmd(2, 32'h100, 8'd4, 64'h0);
    rd[2] = 1'b1;
    #1;
    tests++; if ({busy, ddr_rd} !== 2'b00) begin fails++; $display("FAIL rd_idle got %b want 00", {busy, ddr_rd}); end
    cyc();
    #1;
    tests++; if (grant !== 3'b100) begin fails++; $display("FAIL rd_grant got %b want 100", grant); end
    tests++; if ({ddr_rd, ddr_addr, ddr_burstCount} !== {1'b1, 32'h100, 8'd4}) begin fails++; $display("FAIL rd_cmd got %b %h %0d want 1 100 4", ddr_rd, ddr_addr, ddr_burstCount); end
    tests++; if (in_waitReq !== 3'b011) begin fails++; $display("FAIL rd_waitreq got %b want 011", in_waitReq); end
    cyc();
    rd[2] = 1'b0;
    for (int c = 0; c < 8 && n < 4; c++) begin
      ddr_valid = pat[c];
      ddr_dout = 64'hA0 + 64'(n);
      #1;
      tests++; if (in_valid !== (pat[c] ? 3'b100 : 3'b000)) begin fails++; $display("FAIL rd_valid c%0d got %b want %b", c, in_valid, pat[c] ? 3'b100 : 3'b000); end
      tests++; if ({busy, ddr_rd} !== 2'b10) begin fails++; $display("FAIL rd_busy c%0d got %b want 10", c, {busy, ddr_rd}); end
      if (pat[c]) begin
        tests++; if (in_dout !== 64'hA0 + 64'(n)) begin fails++; $display("FAIL rd_dout got %h want %h", in_dout, 64'hA0 + 64'(n)); end
        n++;
      end
      cyc();
    end
    ddr_valid = 1'b0;
    #1;
    tests++; if (n !== 4) begin fails++; $display("FAIL rd_beats got %0d want 4", n); end
    tests++; if ({busy, grant, in_valid} !== 7'b0) begin fails++; $display("FAIL rd_end got %b want 0000000", {busy, grant, in_valid}); end
  endtask
  task automatic test_contention;
    logic [2:0] exp [4] = '{3'b001, 3'b010, 3'b100, 3'b001};
    int w [4] = '{0, 1, 2, 0};
    reset = 1'b1;
    for (int i = 0; i < 3; i++) set_cmd(i, 32'h1000 * (i + 1), 8'd1, 64'hC0 + 64'(i));
    wr = 3'b111;
    cyc();
    reset = 1'b0;
    #1;
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL ct_start got %b want 0", busy); end
    for (int j = 0; j < 4; j++) begin
      cyc();
      #1;
      tests++; if (grant !== exp[j]) begin fails++; $display("FAIL ct_grant%0d got %b want %b", j, grant, exp[j]); end
      tests++; if ({ddr_wr, ddr_addr, ddr_din} !== {1'b1, 32'h1000 * (w[j] + 1), 64'hC0 + 64'(w[j])}) begin fails++; $display("FAIL ct_cmd%0d got %b %h %h", j, ddr_wr, ddr_addr, ddr_din); end
      tests++; if (in_waitReq !== ~exp[j]) begin fails++; $display("FAIL ct_waitreq%0d got %b want %b", j, in_waitReq, ~exp[j]); end
      cyc();
      #1;
      tests++; if ({busy, ddr_wr} !== 2'b00) begin fails++; $display("FAIL ct_dead%0d got %b want 00", j, {busy, ddr_wr}); end
      if (j == 3) wr = 3'b000;
    end
    cyc();
    #1;
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL ct_end got %b want 0", busy); end
  endtask
  task automatic test_write_wait;
    int n = 0, k = 0;
    logic wq;
    set_cmd(1, 32'h2000, 8'd8, 64'hD000_0000_0000_0000);
    wr[1] = 1'b1;
    cyc();
    while (n < 8 && k < 30) begin
      wq = (k >= 3 && k <= 5);
      ddr_waitReq = wq;
      din[64 +: 64] = 64'hD000_0000_0000_0000 + 64'(n);
      #1;
      tests++; if (in_waitReq !== {1'b1, wq, 1'b1}) begin fails++; $display("FAIL wr_waitreq k%0d got %b want %b", k, in_waitReq, {1'b1, wq, 1'b1}); end
      tests++; if ({ddr_wr, ddr_burstCount, ddr_din} !== {1'b1, 8'd8, 64'hD000_0000_0000_0000 + 64'(n)}) begin fails++; $display("FAIL wr_cmd k%0d got %b %0d %h", k, ddr_wr, ddr_burstCount, ddr_din); end
      if (!wq) n++;
      k++;
      cyc();
    end
    wr[1] = 1'b0;
    ddr_waitReq = 1'b0;
    #1;
    tests++; if (k !== 11) begin fails++; $display("FAIL wr_cycles got %0d want 11", k); end
    tests++; if ({busy, ddr_wr, grant} !== 5'b0) begin fails++; $display("FAIL wr_end got %b want 00000", {busy, ddr_wr, grant}); end
  endtask
  task automatic test_burst0;
    set_cmd(0, 32'h40, 8'd0, 64'h0);
    rd[0] = 1'b1;
    cyc();
    #1;
    tests++; if ({grant, ddr_rd, ddr_burstCount} !== {3'b001, 1'b1, 8'd0}) begin fails++; $display("FAIL b0_cmd got %b %b %0d want 001 1 0", grant, ddr_rd, ddr_burstCount); end
    cyc();
    rd[0] = 1'b0;
    ddr_valid = 1'b1;
    #1;
    tests++; if ({in_valid, ddr_rd} !== 4'b0010) begin fails++; $display("FAIL b0_valid got %b want 0010", {in_valid, ddr_rd}); end
    cyc();
    ddr_valid = 1'b0;
    #1;
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL b0_end got %b want 0", busy); end
  endtask
  task automatic test_stray_valid;
    ddr_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      tests++; if ({busy, in_valid, grant} !== 7'b0) begin fails++; $display("FAIL stray c%0d got %b want 0000000", c, {busy, in_valid, grant}); end
      cyc();
    end
    ddr_valid = 1'b0;
  endtask
  task automatic test_reset_mid;
    set_cmd(2, 32'h200, 8'd4, 64'h0);
    rd[2] = 1'b1;
    cyc();
    cyc();
    rd[2] = 1'b0;
    ddr_valid = 1'b1;
    #1;
    tests++; if (in_valid !== 3'b100) begin fails++; $display("FAIL rm_beat got %b want 100", in_valid); end
    cyc();
    cyc();
    reset = 1'b1;
    #1;
    tests++; if ({busy, grant, in_valid, ddr_rd, ddr_wr} !== 9'b0) begin fails++; $display("FAIL rm_reset got %b want 0", {busy, grant, in_valid, ddr_rd, ddr_wr}); end
    tests++; if (in_waitReq !== 3'b111) begin fails++; $display("FAIL rm_waitreq got %b want 111", in_waitReq); end
    cyc();
    reset = 1'b0;
    set_cmd(0, 32'h80, 8'd2, 64'h0);
    rd = 3'b101;
    #1;
    tests++; if ({busy, in_valid} !== 4'b0) begin fails++; $display("FAIL rm_stray got %b want 0000", {busy, in_valid}); end
    cyc();
    ddr_waitReq = 1'b1;
    #1;
    tests++; if ({grant, in_valid, in_waitReq} !== 9'b001_000_111) begin fails++; $display("FAIL rm_first got %b want 001000111", {grant, in_valid, in_waitReq}); end
    rd = 3'b000;
    ddr_valid = 1'b0;
    ddr_waitReq = 1'b0;
    cyc();
    #1;
    tests++; if ({busy, grant} !== 4'b0) begin fails++; $display("FAIL rm_abandon got %b want 0000", {busy, grant}); end
  endtask
  initial begin
    test_reset();
    test_single_read();
    test_contention();
    test_write_wait();
    test_burst0();
    test_stray_valid();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
